bcd_counter_seg7: RTL and testbench
===================================

// Module: bcd_counter_seg7
// PURPOSE
// - Parametrised successor to the fixed 2-digit 1 s display counter: DIGITS-wide BCD up/down counter
//   with built-in prescaler, enable, parallel load, wrap strobe and per-digit 7-seg decode.
// - Sits between board I/O (clk, buttons/switches) and the 7-seg/LED pins in top-level designs.
// PARAMETERS
// - FREQUENCY  50_000_000  input clock frequency in Hz
// - TICK_HZ    1           count rate in Hz; DIV = FREQUENCY/TICK_HZ, DIV >= 2 required (elaboration error otherwise)
// - DIGITS     2           number of BCD digits, 1..8
// PORTS
// - clk          in   1          system clock, rising edge
// - rst          in   1          asynchronous reset, active-high
// - en           in   1          1 = prescaler runs; 0 = prescaler and count hold
// - up_dn        in   1          1 = count up, 0 = count down; sampled on the counting edge
// - load         in   1          synchronous parallel load strobe
// - load_val     in   4*DIGITS   BCD load value, digit 0 in [3:0]
// - bcd_out      out  4*DIGITS   current count, registered, digit 0 in [3:0]
// - seg7led_out  out  8*DIGITS   7-seg pattern per digit, digit 0 in [7:0]; active-low, bit0=a..bit6=g, bit7=dp
// - tick_out     out  1          one-cycle strobe: count advanced on the preceding edge
// - wrap_out     out  1          one-cycle strobe: that advance wrapped (99..9->0 up, 0->99..9 down)
// BEHAVIOUR
// - Reset (async, immediate): div_cnt=0, count=0, tick_out=0, wrap_out=0; seg7led_out shows "0" per digit (0xC0).
// - Prescaler div_cnt: 0..DIV-1, width $clog2(DIV). Per edge, priority: load > en.
// - load=1: count<=load_val (each digit >9 clamped to 9), div_cnt<=0, tick_out<=0, wrap_out<=0; ignores en.
// - load=0, en=0: everything holds; tick_out<=0, wrap_out<=0.
// - load=0, en=1, div_cnt<DIV-1: div_cnt++, tick_out<=0, wrap_out<=0.
// - load=0, en=1, div_cnt==DIV-1: div_cnt<=0, count<=next, tick_out<=1, wrap_out<=wrap.
//   tick_out/wrap_out are high in the same cycle bcd_out first shows the new value; period = DIV cycles.
// - Up: BCD ripple increment; digit 9 -> 0 with carry. All digits 9 -> all 0, wrap=1.
// - Down: BCD ripple decrement; digit 0 -> 9 with borrow. All digits 0 -> all 9, wrap=1.
// - en deasserted mid-period: div_cnt retains value; resuming completes the remaining cycles (no restart).
// - Decode combinational from bcd_out: 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90; dp always off.
// - bcd_out never holds a non-BCD digit (load clamp guarantees this); decoder default for >9 is FF.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: every zero digit above the most significant non-zero digit outputs
//   0xFF (blank); digit 0 always displayed (value 0 shows single "0"). bcd_out unaffected.
// - LEADING_ZERO_BLANK_EN undefined: all DIGITS digits always decoded (leading zeros shown as 0xC0).
// TESTING  (FREQUENCY=10, TICK_HZ=1 -> DIV=10, DIGITS=2 unless noted)
// - rst pulse, en=1, up_dn=1: tick_out every 10th cycle; after 3 ticks bcd_out=8'h03, seg7led_out[7:0]=0xB0.
// - load_val=8'h98 load, then 2 ticks up: 8'h99 then 8'h00 with wrap_out=1 for exactly 1 cycle, tick_out=1 both.
// - count 8'h00, up_dn=0, 1 tick: bcd_out=8'h99, wrap_out=1; next tick 8'h98, wrap_out=0.
// - load_val=8'h5F -> bcd_out=8'h59; load asserted on div_cnt==9 edge -> load wins, tick_out=0, next tick 10 cycles later.
// - en=0 after 4 cycles into period for 25 cycles: bcd_out, tick_out=0 held; en=1 -> tick after 6 more cycles.
// - rst asserted mid-period without clock edge: bcd_out=0, strobes 0 immediately; with LEADING_ZERO_BLANK_EN,
//   count 8'h05 -> seg7led_out={8'hFF,8'h92}; without -> {8'hC0,8'h92}.

Source files
------------

// File: rtl/bcd_counter_seg7_if.sv
// Bus bundle for bcd_counter_seg7: control/load inputs and count/display/strobe outputs.
interface bcd_counter_seg7_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [8*DIGITS-1:0]   seg7led_out;
  logic                  tick_out;
  logic                  wrap_out;

  modport master (
    output en, up_dn, load, load_val,
    input  bcd_out, seg7led_out, tick_out, wrap_out
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output bcd_out, seg7led_out, tick_out, wrap_out
  );
endinterface

// File: rtl/bcd_counter_seg7.sv
// DIGITS-wide BCD up/down counter with prescaler, parallel load, wrap strobe and 7-seg decode.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module bcd_counter_seg7 #(
  parameter int unsigned FREQUENCY = 50_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned DIGITS    = 2
) (
  input  logic               clk,
  input  logic               rst,
  bcd_counter_seg7_if.slave  bus
);

  localparam int unsigned DIV   = FREQUENCY / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SEG_W = 8 * DIGITS;

  if (DIV < 2) begin : g_div_chk
    $error("bcd_counter_seg7: FREQUENCY/TICK_HZ must be >= 2");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_chk
    $error("bcd_counter_seg7: DIGITS must be in 1..8");
  end

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [BCD_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [BCD_W-1:0] inc_val, dec_val, load_clamped;
  logic             inc_wrap, dec_wrap;
  logic [SEG_W-1:0] seg_c;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  // Ripple increment/decrement; the final carry/borrow out marks a wrap.
  always_comb begin
    logic carry;
    logic borrow;
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end

  // Non-BCD load digits saturate at 9 so the count register only ever holds BCD.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
    end
  end

  // Next state: load beats enable; count advances on the last prescaler cycle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (bus.load) begin
      count_d   = load_clamped;
      div_cnt_d = '0;
    end else if (bus.en) begin
      if (div_cnt_q == CNT_W'(DIV - 1)) begin
        div_cnt_d = '0;
        count_d   = bus.up_dn ? inc_val : dec_val;
        tick_d    = 1'b1;
        wrap_d    = bus.up_dn ? inc_wrap : dec_wrap;
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  // Per-digit decode, scanned from the top digit so leading zeros can be blanked.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    nz = 1'b0;
`endif
    seg_c = '1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      nz = nz | (count_q[4*i +: 4] != 4'd0);
      if (i != 0 && !nz) begin
        seg_c[8*i +: 8] = 8'hFF;
      end else begin
        seg_c[8*i +: 8] = seg_decode(count_q[4*i +: 4]);
      end
`else
      seg_c[8*i +: 8] = seg_decode(count_q[4*i +: 4]);
`endif
    end
  end

  assign bus.bcd_out     = count_q;
  assign bus.seg7led_out = seg_c;
  assign bus.tick_out    = tick_q;
  assign bus.wrap_out    = wrap_q;

endmodule

// File: tb/tb_bcd_counter_seg7.sv
// Bench for bcd_counter_seg7: directed scenarios plus random stimulus against an integer-valued reference model.
module tb_bcd_counter_seg7;

  localparam int unsigned FREQ   = 10;
  localparam int unsigned TICK   = 1;
  localparam int unsigned DIGITS = 2;
  localparam int          DIV    = 10;
  localparam int          MOD    = 100;
  localparam int          BW     = 4 * DIGITS;
  localparam int          SW     = 8 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_counter_seg7_if #(.DIGITS(DIGITS)) bus_if();

  bcd_counter_seg7 #(
    .FREQUENCY(FREQ),
    .TICK_HZ  (TICK),
    .DIGITS   (DIGITS)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: count as a plain integer modulo 10^DIGITS, prescaler as a phase.
  int   ref_val;
  int   ref_phase;
  logic ref_tick;
  logic ref_wrap;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r = '0;
    for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int v);
    logic [SW-1:0] r = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      int d = (v / pow10(i)) % 10;
      r[8*i +: 8] = seg_tab[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < pow10(i)) r[8*i +: 8] = 8'hFF;
`endif
    end
    return r;
  endfunction

  function automatic int clamp_load(input logic [BW-1:0] lv);
    int s = 0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      int d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      s = s + d * pow10(i);
    end
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("bcd_out",  64'(bus_if.bcd_out),     64'(to_bcd(ref_val)));
    check_eq("tick_out", 64'(bus_if.tick_out),    64'(ref_tick));
    check_eq("wrap_out", 64'(bus_if.wrap_out),    64'(ref_wrap));
    check_eq("seg7",     64'(bus_if.seg7led_out), 64'(exp_seg(ref_val)));
  endtask

  task automatic model_reset();
    ref_val   = 0;
    ref_phase = 0;
    ref_tick  = 1'b0;
    ref_wrap  = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic u, input logic l, input logic [BW-1:0] lv);
    ref_tick = 1'b0;
    ref_wrap = 1'b0;
    if (l) begin
      ref_val   = clamp_load(lv);
      ref_phase = 0;
    end else if (e) begin
      if (ref_phase < DIV - 1) begin
        ref_phase++;
      end else begin
        ref_phase = 0;
        ref_tick  = 1'b1;
        if (u) begin
          ref_wrap = (ref_val == MOD - 1);
          ref_val  = (ref_val + 1) % MOD;
        end else begin
          ref_wrap = (ref_val == 0);
          ref_val  = (ref_val + MOD - 1) % MOD;
        end
      end
    end
  endtask

  // Drive one edge's inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic e, input logic u, input logic l, input logic [BW-1:0] lv);
    bus_if.en       = e;
    bus_if.up_dn    = u;
    bus_if.load     = l;
    bus_if.load_val = lv;
    model_step(e, u, l, lv);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst             = 1'b1;
    bus_if.en       = 1'b0;
    bus_if.up_dn    = 1'b1;
    bus_if.load     = 1'b0;
    bus_if.load_val = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check_eq("rst_seg0", 64'(bus_if.seg7led_out[7:0]), 64'hC0);
    rst = 1'b0;

    // Free-running up count: three ticks in 30 cycles.
    repeat (30) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("up3_bcd",  64'(bus_if.bcd_out), 64'h03);
    check_eq("up3_seg0", 64'(bus_if.seg7led_out[7:0]), 64'hB0);
    check_eq("up3_tick", 64'(bus_if.tick_out), 64'h1);

    // Load 98 and wrap upward.
    cycle(1'b1, 1'b1, 1'b1, 8'h98);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("up_99", 64'(bus_if.bcd_out), 64'h99);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("up_wrap_bcd", 64'(bus_if.bcd_out), 64'h00);
    check_eq("up_wrap",     64'(bus_if.wrap_out), 64'h1);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("up_wrap_1cyc", 64'(bus_if.wrap_out), 64'h0);

    // Down from 00 wraps to 99, then 98 without wrap.
    cycle(1'b1, 1'b1, 1'b1, 8'h00);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("dn_wrap_bcd", 64'(bus_if.bcd_out), 64'h99);
    check_eq("dn_wrap",     64'(bus_if.wrap_out), 64'h1);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("dn_98",      64'(bus_if.bcd_out), 64'h98);
    check_eq("dn_98_wrap", 64'(bus_if.wrap_out), 64'h0);

    // Clamped load, then a load on the terminal prescaler edge beats the tick.
    cycle(1'b0, 1'b1, 1'b1, 8'h5F);
    check_eq("clamp", 64'(bus_if.bcd_out), 64'h59);
    repeat (9) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 8'h12);
    check_eq("load_win_tick", 64'(bus_if.tick_out), 64'h0);
    check_eq("load_win_bcd",  64'(bus_if.bcd_out), 64'h12);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("after_load_tick", 64'(bus_if.tick_out), 64'h1);

    // Enable pause mid-period resumes without restarting the prescaler.
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (25) cycle(1'b0, 1'b1, 1'b0, '0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("resume_tick", 64'(bus_if.tick_out), 64'h1);
    check_eq("resume_bcd",  64'(bus_if.bcd_out), 64'h14);

    // Random stimulus.
    for (int n = 0; n < 3000; n++) begin
      logic          e, u, l;
      logic [BW-1:0] lv;
      e  = ($urandom_range(0, 7) != 0);
      u  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 59) == 0);
      lv = BW'($urandom);
      cycle(e, u, l, lv);
    end

    // Asynchronous reset mid-period, between clock edges.
    cycle(1'b0, 1'b1, 1'b1, 8'h05);
    check_eq("seg_05", 64'(bus_if.seg7led_out), 64'(exp_seg(5)));
    repeat (4) cycle(1'b1, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_eq("async_rst_bcd", 64'(bus_if.bcd_out), 64'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("post_rst_bcd", 64'(bus_if.bcd_out), 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
